cpu_run_ctrl: RTL and testbench

- Run/halt/single-step controller for the pipelined CPU on the board.
- Produces a CPU clock-enable from a run switch, a debounced step button and a PC breakpoint, and counts committed instructions.
- Sits between the board switches/buttons and the CPU core. It consumes the core's debug PC and commit strobe. Its state, breakpoint hit and count feed the LEDs and the debug display.

---
 rtl/cpu_run_ctrl_if.sv | 19 +
 rtl/cpu_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Debug link between the CPU core and the run controller.
// The core drives its commit PC and strobe and receives the clock enable.
interface cpu_run_ctrl_if;
    logic [31:0] dbg_pc;
    logic        dbg_commit;
    logic        cpu_en;

    modport master (
        output dbg_pc,
        output dbg_commit,
        input  cpu_en
    );

    modport slave (
        input  dbg_pc,
        input  dbg_commit,
        output cpu_en
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: conditions the run switch and step button,
// gates the CPU clock enable, stops on a PC breakpoint and counts commits.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_MAX        = 64,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
    cpu_run_ctrl_if.slave        core,
    input  logic                 cnt_clr,
    output logic                 halted,
    output logic                 bp_hit,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     commit_cnt
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    // Bit 0 is the run switch, bit 1 the step button.
    logic [1:0] raw_in;
    logic [1:0] db_vec;
    assign raw_in = {step_btn, run_sw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    logic run_db;
    logic step_db_d_reg;
    logic step_pulse;

    assign run_db = db_vec[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            step_db_d_reg <= 1'b0;
        end else begin
            step_db_d_reg <= db_vec[1];
        end
    end

    // Rising edge only, so a held button yields a single step.
    assign step_pulse = db_vec[1] & ~step_db_d_reg;

    state_t          state_reg;
    logic [ST_W-1:0] step_timer_reg;
    logic            bp_match;

    assign bp_match = bp_en && core.dbg_commit && (core.dbg_pc == bp_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_HALT;
            step_timer_reg <= '0;
        end else begin
            case (state_reg)
                ST_HALT: begin
                    if (run_db) begin
                        state_reg <= ST_RUN;
                    end else if (step_pulse) begin
                        state_reg      <= ST_STEP;
                        step_timer_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (bp_match) begin
                        state_reg <= ST_BREAK;
                    end else if (!run_db) begin
                        state_reg <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    // Breakpoint and run switch are deliberately ignored here.
                    if (core.dbg_commit) begin
                        state_reg <= ST_HALT;
                    end else if (step_timer_reg == ST_W'(STEP_MAX - 1)) begin
                        state_reg <= ST_HALT;
                    end else begin
                        step_timer_reg <= step_timer_reg + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (!run_db) begin
                        state_reg <= ST_HALT;
                    end else if (step_pulse) begin
                        state_reg      <= ST_STEP;
                        step_timer_reg <= '0;
                    end
                end
                default: state_reg <= ST_HALT;
            endcase
        end
    end

    assign core.cpu_en = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign halted      = (state_reg == ST_HALT) || (state_reg == ST_BREAK);
    assign bp_hit      = (state_reg == ST_BREAK);
    assign state       = state_reg;

    logic [CNT_W-1:0] commit_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            commit_cnt_reg <= '0;
        end else if (core.dbg_commit && core.cpu_en && (commit_cnt_reg != '1)) begin
            commit_cnt_reg <= commit_cnt_reg + 1'b1;
        end
    end

    assign commit_cnt = commit_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a 4-cycle debounce and a 4-bit counter.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic        cnt_clr = 1'b0;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  state;
    logic [3:0]  commit_cnt;

    int check_cnt = 0;
    int error_cnt = 0;

    cpu_run_ctrl_if core_if ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .STEP_MAX        (64),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .core       (core_if.slave),
        .cnt_clr    (cnt_clr),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .state      (state),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic commit(input logic [31:0] pc);
        core_if.dbg_pc     = pc;
        core_if.dbg_commit = 1'b1;
        tick();
        core_if.dbg_commit = 1'b0;
    endtask

    initial begin
        int any_nonhalt;
        int step_entries;
        int halt_edge;
        logic [1:0] prev_state;

        core_if.dbg_pc     = 32'h0;
        core_if.dbg_commit = 1'b0;

        // Reset and idle
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'h0);
        check("rst_cpu_en", 32'(core_if.cpu_en), 32'h0);
        check("rst_halted", 32'(halted), 32'h1);
        check("rst_bp_hit", 32'(bp_hit), 32'h0);
        check("rst_cnt", 32'(commit_cnt), 32'h0);

        // Bouncy step button never stable for 4 cycles
        any_nonhalt = 0;
        step_btn = 1'b1; ticks(2);
        step_btn = 1'b0; ticks(2);
        step_btn = 1'b1; ticks(2);
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (state != 2'b00) any_nonhalt++;
        end
        check("bounce_no_step", 32'(any_nonhalt), 32'h0);

        // Run switch latency and commit counting
        run_sw = 1'b1;
        ticks(6);
        check("run_lat6", 32'(state), 32'h0);
        tick();
        check("run_lat7", 32'(state), 32'h1);
        check("run_cpu_en", 32'(core_if.cpu_en), 32'h1);
        check("run_halted", 32'(halted), 32'h0);
        for (int i = 0; i < 10; i++) commit(32'h100 + 32'(4 * i));
        check("run_cnt10", 32'(commit_cnt), 32'hA);
        run_sw = 1'b0;
        ticks(6);
        check("stop_lat6", 32'(state), 32'h1);
        tick();
        check("stop_lat7", 32'(state), 32'h0);

        // Held step button with commits every 3rd cycle
        step_entries = 0;
        halt_edge    = -1;
        prev_state   = state;
        step_btn     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            core_if.dbg_pc     = 32'h200 + 32'(i);
            core_if.dbg_commit = (i % 3 == 2);
            tick();
            if (state == 2'b10 && prev_state != 2'b10) step_entries++;
            if (state == 2'b00 && prev_state == 2'b10 && halt_edge < 0) halt_edge = i + 1;
            prev_state = state;
        end
        core_if.dbg_commit = 1'b0;
        step_btn = 1'b0;
        check("step_entries", 32'(step_entries), 32'h1);
        check("step_halt_edge", 32'(halt_edge), 32'h9);
        check("step_cnt11", 32'(commit_cnt), 32'hB);
        ticks(8);
        check("step_idle", 32'(state), 32'h0);

        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("clr_cnt", 32'(commit_cnt), 32'h0);

        // Breakpoint at 0x40
        bp_en   = 1'b1;
        bp_addr = 32'h40;
        run_sw  = 1'b1;
        ticks(7);
        check("bp_run", 32'(state), 32'h1);
        commit(32'h38);
        check("bp_after38", 32'(state), 32'h1);
        commit(32'h3C);
        commit(32'h40);
        check("bp_state", 32'(state), 32'h3);
        check("bp_cpu_en", 32'(core_if.cpu_en), 32'h0);
        check("bp_hit", 32'(bp_hit), 32'h1);
        check("bp_halted", 32'(halted), 32'h1);
        check("bp_cnt", 32'(commit_cnt), 32'h3);
        commit(32'h44);
        check("bp_ignored_cnt", 32'(commit_cnt), 32'h3);
        check("bp_hold", 32'(state), 32'h3);
        step_btn = 1'b1;
        ticks(7);
        check("bp_step", 32'(state), 32'h2);
        commit(32'h40);
        check("bp_step_halt", 32'(state), 32'h0);
        check("bp_step_cnt", 32'(commit_cnt), 32'h4);
        tick();
        check("bp_resume_run", 32'(state), 32'h1);
        run_sw   = 1'b0;
        step_btn = 1'b0;
        ticks(7);
        check("bp_sw_off", 32'(state), 32'h0);
        run_sw = 1'b1;
        ticks(7);
        check("bp_sw_on", 32'(state), 32'h1);
        run_sw = 1'b0;
        bp_en  = 1'b0;
        ticks(7);
        check("pre_to_halt", 32'(state), 32'h0);

        // Step timeout with no commit
        step_btn = 1'b1;
        ticks(7);
        check("to_step", 32'(state), 32'h2);
        ticks(63);
        check("to_still_step", 32'(state), 32'h2);
        tick();
        check("to_halt", 32'(state), 32'h0);
        check("to_cnt", 32'(commit_cnt), 32'h4);
        step_btn = 1'b0;
        ticks(8);

        // Saturation, clear priority, reset mid-run
        run_sw = 1'b1;
        ticks(7);
        check("sat_run", 32'(state), 32'h1);
        for (int i = 0; i < 11; i++) commit(32'h300);
        check("sat_15", 32'(commit_cnt), 32'hF);
        for (int i = 0; i < 3; i++) commit(32'h304);
        check("sat_hold", 32'(commit_cnt), 32'hF);
        cnt_clr = 1'b1;
        commit(32'h308);
        cnt_clr = 1'b0;
        check("clr_prio", 32'(commit_cnt), 32'h0);
        commit(32'h30C);
        check("post_clr_cnt", 32'(commit_cnt), 32'h1);
        reset = 1'b1;
        tick();
        check("rst_run_state", 32'(state), 32'h0);
        check("rst_run_cpu_en", 32'(core_if.cpu_en), 32'h0);
        check("rst_run_cnt", 32'(commit_cnt), 32'h0);
        reset = 1'b0;
        tick();
        check("rst_run_hold", 32'(state), 32'h0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
